// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter (double-dabble) feeding a multiplexed four-digit
// seven-segment scanner with optional leading-zero blanking.
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        load,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    localparam int unsigned PreW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StLatch} state_e;

    state_e      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d, bcd_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic [PreW-1:0] pre_q, pre_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      digit_q, digit_d;
    logic [3:0]      an_q, an_d;
    logic            blank;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        bcd_adj    = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d    = StConv;
                    bin_d      = (value > 14'd9999) ? 14'd9999 : value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (value > 14'd9999);
                end
            end
            StConv: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd13) state_d = StLatch;
            end
            StLatch: begin
                disp_d  = bcd_q;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Slot outputs are refreshed only at slot boundaries, so a new display
    // value appears at the next slot without disturbing the scan cadence.
    always_comb begin
        pre_d   = pre_q + PreW'(1);
        idx_d   = idx_q;
        digit_d = digit_q;
        an_d    = an_q;
        blank   = 1'b0;
        if (pre_q == PreW'(REFRESH_DIV - 1)) begin
            pre_d   = '0;
            idx_d   = idx_q + 2'd1;
            digit_d = disp_q[{idx_d, 2'b00} +: 4];
            case (idx_d)
                2'd1:    blank = BLANK_LZ && (disp_q[15:4] == 12'd0);
                2'd2:    blank = BLANK_LZ && (disp_q[15:8] == 8'd0);
                2'd3:    blank = BLANK_LZ && (disp_q[15:12] == 4'd0);
                default: blank = 1'b0;
            endcase
            an_d = blank ? 4'b1111 : ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            pre_q      <= '0;
            idx_q      <= '0;
            digit_q    <= '0;
            an_q       <= 4'b1110;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            digit_q    <= digit_d;
            an_q       <= an_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign digit = digit_q;
    assign an    = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: directed scenarios plus random loads, every
// cycle compared against an arithmetic reference model of the display.
module tb_bcd_display_scanner;

    localparam int unsigned DIV   = 4;
    localparam bit          BLANK = 1'b1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        load  = 1'b0;
    logic [13:0] value = '0;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model state
    int       m_left;
    int       m_pend;
    bit       m_pend_ovf;
    int       m_disp;
    bit       m_ovf;
    bit       m_done;
    int       m_pre;
    int       m_idx;
    logic [3:0] m_digit;
    logic [3:0] m_an;

    bcd_display_scanner #(
        .REFRESH_DIV(DIV),
        .BLANK_LZ   (BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .value(value),
        .load (load),
        .digit(digit),
        .an   (an),
        .busy (busy),
        .done (done),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_slot(input int d, input int idx);
        m_digit = 4'((d / pow10(idx)) % 10);
        if (BLANK && idx > 0 && d < pow10(idx)) m_an = 4'b1111;
        else m_an = ~(4'b0001 << idx);
    endtask

    task automatic model_reset();
        m_left = 0; m_pend = 0; m_pend_ovf = 0; m_disp = 0; m_ovf = 0; m_done = 0;
        m_pre = 0; m_idx = 0; m_digit = 4'd0; m_an = 4'b1110;
    endtask

    task automatic model_edge(input bit ld, input int v);
        int old_disp = m_disp;
        m_done = 0;
        if (m_left == 0) begin
            if (ld) begin
                m_left     = 15;
                m_pend     = (v > 9999) ? 9999 : v;
                m_pend_ovf = (v > 9999);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_disp = m_pend;
                m_ovf  = m_pend_ovf;
                m_done = 1;
            end
        end
        if (m_pre == DIV - 1) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % 4;
            model_slot(old_disp, m_idx);
        end else begin
            m_pre++;
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check4("digit", digit, m_digit);
        check4("an", an, m_an);
        check1("busy", busy, m_left > 0);
        check1("done", done, m_done);
        check1("ovf", ovf, m_ovf);
        if (done === 1'b1) done_seen++;
    endtask

    task automatic step(input bit ld, input logic [13:0] v);
        load  = ld;
        value = v;
        @(posedge clk);
        if (rst_n) model_edge(ld, int'(v));
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 14'd0);
    endtask

    task automatic hit_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        model_reset();
        #1;
        hit_reset();
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // 1234: latency, busy window, slot sequence
        step(1'b1, 14'd1234);
        idle(40);

        // 42: leading-zero blanking
        step(1'b1, 14'd42);
        idle(35);

        // Overflow saturation, then clearing
        step(1'b1, 14'd12000);
        idle(35);
        step(1'b1, 14'd5);
        idle(35);

        // Load during conversion is ignored; exactly one done pulse
        step(1'b1, 14'd1234);
        done_seen = 0;
        idle(4);
        step(1'b1, 14'd5678);
        idle(30);
        n_cmp++;
        assert (done_seen == 1) else begin
            n_bad++;
            $error("FAIL done_count: observed %0d expected 1", done_seen);
        end

        // Zero shows only slot 0
        step(1'b1, 14'd0);
        idle(35);

        // Reset mid-conversion aborts with no update
        step(1'b1, 14'd9999);
        idle(7);
        hit_reset();
        idle(3);
        rst_n = 1'b1;
        step(1'b1, 14'd321);
        idle(40);

        // Load held high: back-to-back conversions
        for (int i = 0; i < 60; i++) step(1'b1, 14'($urandom));

        // Random loads
        for (int i = 0; i < 800; i++) step($urandom_range(0, 3) == 0, 14'($urandom));
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
